// File: rtl/sudoku_pkg.sv
// sudoku_pkg: frame geometry and deserializer state encoding shared by both link ends.
package sudoku_pkg;
  localparam int DEF_DATA_WIDTH = 324;
  localparam int DEF_UNIT_WIDTH = 4;
  localparam int DEF_CHUNK_WIDTH = 8;
  function automatic int num_chunks(input int dw, input int cw);
    return (dw + cw - 1) / cw;
  endfunction
  function automatic int pad_bits(input int dw, input int cw);
    return num_chunks(dw, cw) * cw - dw;
  endfunction
  typedef enum logic [1:0] {IDLE, RECEIVE, HOLD} deser_state_t;
endpackage

// File: rtl/idle_timeout_counter.sv
// idle_timeout_counter: counts idle enabled cycles and pulses o_expire on the TIMEOUT_CYCLES-th; 0 disables.
module idle_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] r_tmo;
  assign o_expire = (TIMEOUT_CYCLES != 0) && i_enable && !i_clear && r_tmo == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst || i_clear || o_expire) r_tmo <= '0;
    else if (i_enable) r_tmo <= r_tmo + 1'b1;
  end
endmodule

// File: rtl/nibble_unpacker_deserializer.sv
// nibble_unpacker_deserializer: rebuilds one padded, MSB-first byte frame into a word behind a valid/ready handshake.
module nibble_unpacker_deserializer #(
  parameter int DATA_WIDTH = sudoku_pkg::DEF_DATA_WIDTH,
  parameter int UNIT_WIDTH = sudoku_pkg::DEF_UNIT_WIDTH,
  parameter int CHUNK_WIDTH = sudoku_pkg::DEF_CHUNK_WIDTH,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CHUNK_WIDTH-1:0] uart_rx_data,
  input  logic                   uart_rx_valid,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic                   busy,
  output logic                   frame_error,
  output logic                   overrun
);
  import sudoku_pkg::*;
  localparam int NUM_CHUNKS = num_chunks(DATA_WIDTH, CHUNK_WIDTH);
  localparam int PAD_BITS = pad_bits(DATA_WIDTH, CHUNK_WIDTH);
  localparam int SBW = NUM_CHUNKS * CHUNK_WIDTH;
  localparam int CNW = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CHUNK_WIDTH-1:0] PAD_MASK = CHUNK_WIDTH'((1 << PAD_BITS) - 1);
  if ((DATA_WIDTH % UNIT_WIDTH) != 0) begin : g_bad_geometry
    $error("DATA_WIDTH must be a multiple of UNIT_WIDTH");
  end
  deser_state_t r_state, w_state_nx;
  logic [CNW-1:0] r_cnt, w_cnt_nx;
  logic [SBW-CHUNK_WIDTH-1:0] r_sbuf;
  logic [SBW-1:0] w_shift;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic r_data_valid, w_valid_nx, r_frame_error, w_ferr, r_overrun, w_ovr, w_take, w_load;
  logic w_last, w_pad_bad, w_expire;
  // Only the previous NUM_CHUNKS-1 bytes need storing; the live byte completes the frame.
  assign w_shift = {r_sbuf, uart_rx_data};
  assign w_last = r_cnt == CNW'(NUM_CHUNKS - 1);
  assign w_pad_bad = |(uart_rx_data & PAD_MASK);
  idle_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk(clk),
    .rst(rst),
    .i_clear(uart_rx_valid || r_state != RECEIVE),
    .i_enable(r_state == RECEIVE && !uart_rx_valid),
    .o_expire(w_expire)
  );
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx = r_cnt;
    w_valid_nx = r_data_valid;
    w_take = 1'b0;
    w_load = 1'b0;
    w_ferr = 1'b0;
    w_ovr = 1'b0;
    case (r_state)
      IDLE: if (uart_rx_valid) begin
        w_take = 1'b1;
        w_cnt_nx = CNW'(1);
        w_state_nx = RECEIVE;
      end
      RECEIVE: if (uart_rx_valid) begin
        w_take = 1'b1;
        w_cnt_nx = w_last ? '0 : r_cnt + 1'b1;
        w_ferr = w_last && w_pad_bad;
        w_load = w_last && !w_pad_bad;
        w_valid_nx = r_data_valid || w_load;
        w_state_nx = !w_last ? RECEIVE : w_pad_bad ? IDLE : HOLD;
      end else if (w_expire) begin
        w_ferr = 1'b1;
        w_cnt_nx = '0;
        w_state_nx = IDLE;
      end
      default: if (data_ready) begin
        w_valid_nx = 1'b0;
        w_take = uart_rx_valid;
        w_cnt_nx = uart_rx_valid ? CNW'(1) : r_cnt;
        w_state_nx = uart_rx_valid ? RECEIVE : IDLE;
      end else begin
        w_ovr = uart_rx_valid;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_sbuf <= '0;
      r_data_out <= '0;
      r_data_valid <= 1'b0;
      r_frame_error <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt <= w_cnt_nx;
      if (w_take) r_sbuf <= w_shift[SBW-CHUNK_WIDTH-1:0];
      if (w_load) r_data_out <= w_shift[SBW-1 -: DATA_WIDTH];
      r_data_valid <= w_valid_nx;
      r_frame_error <= w_ferr;
      r_overrun <= w_ovr;
    end
  end
  assign data_out = r_data_out;
  assign data_valid = r_data_valid;
  assign busy = r_state == RECEIVE;
  assign frame_error = r_frame_error;
  assign overrun = r_overrun;
endmodule

// File: tb/tb_nibble_unpacker_deserializer.sv
// tb_nibble_unpacker_deserializer: directed plus random frames checked every cycle against a byte-queue model.
module tb_nibble_unpacker_deserializer;
  localparam int DW = 324;
  localparam int NC = 41;
  localparam int TO = 16;
  localparam logic [DW-1:0] GOLD = {4'h5, 4'h6, 4'h7, 4'h8, 300'b0, 4'h1, 4'h2};
  logic clk = 1'b0, rst = 1'b1, rx_v = 1'b0, rdy = 1'b0;
  logic [7:0] rx_d = '0;
  logic [DW-1:0] data_out;
  logic dv, busy, ferr, ovr;
  int n_tests = 0, n_fail = 0;
  logic [7:0] m_q[$];
  logic [DW-1:0] m_data = '0;
  bit m_valid = 0, m_ferr = 0, m_ovr = 0;
  int m_idle = 0;
  always #5 clk = ~clk;
  nibble_unpacker_deserializer #(.DATA_WIDTH(DW), .UNIT_WIDTH(4), .CHUNK_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .uart_rx_data(rx_d), .uart_rx_valid(rx_v),
    .data_out(data_out), .data_valid(dv), .data_ready(rdy),
    .busy(busy), .frame_error(ferr), .overrun(ovr)
  );
  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  // Frame word: bytes laid out MSB-first, then the trailing pad nibble dropped.
  function automatic logic [DW-1:0] pack();
    logic [NC*8-1:0] w = '0;
    for (int i = 0; i < NC; i++) w[NC*8-1-8*i -: 8] = m_q[i];
    return w[NC*8-1:NC*8-DW];
  endfunction
  task automatic model_edge();
    m_ferr = 0;
    m_ovr = 0;
    if (rst) begin
      m_q.delete();
      m_data = '0;
      m_valid = 0;
      m_idle = 0;
    end else if (m_valid) begin
      if (rdy) begin
        m_valid = 0;
        if (rx_v) begin
          m_q.push_back(rx_d);
          m_idle = 0;
        end
      end else if (rx_v) m_ovr = 1;
    end else if (rx_v) begin
      m_q.push_back(rx_d);
      m_idle = 0;
      if (m_q.size() == NC) begin
        if (rx_d[3:0] != 4'h0) m_ferr = 1;
        else begin
          m_data = pack();
          m_valid = 1;
        end
        m_q.delete();
      end
    end else if (m_q.size() != 0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_ferr = 1;
        m_q.delete();
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("data_out", data_out, m_data);
    check("data_valid", DW'(dv), DW'(m_valid));
    check("busy", DW'(busy), DW'(m_q.size() != 0));
    check("frame_error", DW'(ferr), DW'(m_ferr));
    check("overrun", DW'(ovr), DW'(m_ovr));
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    rx_v = 1'b1;
    rx_d = b;
    step();
    rx_v = 1'b0;
    repeat (gap) step();
  endtask
  task automatic send_golden(input logic [7:0] last, input int gap);
    for (int i = 0; i < NC; i++)
      send(i == 0 ? 8'h56 : i == 1 ? 8'h78 : i == NC-2 ? 8'h01 : i == NC-1 ? last : 8'h00, i == NC-1 ? 0 : gap);
  endtask
  task automatic accept();
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    check("accept_valid_low", DW'(dv), '0);
  endtask
  initial begin
    repeat (2) step();
    check("rst_data", data_out, '0);
    check("rst_flags", DW'({dv, busy, ferr, ovr}), '0);
    rst = 1'b0;
    step();
    send_golden(8'h20, 3);
    check("gold_data", data_out, GOLD);
    check("gold_valid", DW'(dv), DW'(1));
    check("gold_busy", DW'(busy), '0);
    accept();
    send_golden(8'h23, 1);
    check("badpad_err", DW'(ferr), DW'(1));
    check("badpad_valid", DW'(dv), '0);
    step();
    send_golden(8'h20, 0);
    check("after_badpad", data_out, GOLD);
    accept();
    for (int i = 0; i < 10; i++) send(8'($urandom), 0);
    repeat (TO + 4) step();
    check("timeout_busy", DW'(busy), '0);
    send_golden(8'h20, 2);
    check("after_timeout", data_out, GOLD);
    accept();
    send_golden(8'h20, 0);
    send(8'hAA, 1);
    send(8'hBB, 1);
    check("bp_data", data_out, GOLD);
    check("bp_valid", DW'(dv), DW'(1));
    accept();
    send_golden(8'h20, 0);
    rdy = 1'b1;
    rx_v = 1'b1;
    rx_d = 8'h9C;
    step();
    rdy = 1'b0;
    rx_v = 1'b0;
    check("simul_busy", DW'(busy), DW'(1));
    check("simul_ovr", DW'(ovr), '0);
    for (int i = 1; i < NC; i++) send(i == NC-1 ? {4'($urandom), 4'h0} : 8'($urandom), 0);
    check("simul_valid", DW'(dv), DW'(1));
    accept();
    for (int i = 0; i < 20; i++) send(8'($urandom), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_data", data_out, '0);
    check("midrst_flags", DW'({dv, busy, ferr, ovr}), '0);
    send_golden(8'h20, 0);
    check("after_rst", data_out, GOLD);
    accept();
    for (int f = 0; f < 30; f++)
      for (int i = 0; i < NC; i++) begin
        rdy = 1'($urandom_range(0, 1));
        send(i == NC-1 && $urandom_range(0, 4) != 0 ? {4'($urandom), 4'h0} : 8'($urandom),
             $urandom_range(0, 59) == 0 ? TO + 2 : $urandom_range(0, 3));
      end
    accept();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/nibble_unpacker_deserializer.md
Name: nibble_unpacker_deserializer

Overview:
Receive-side counterpart of the board nibble-packer serializer. It takes the byte stream from the UART receiver and rebuilds one DATA_WIDTH-bit word per frame. Bytes arrive MSB-first, two UNIT_WIDTH nibbles per byte, and the final byte's low nibble is zero padding. The rebuilt word is presented to the sudoku core through a valid/ready handshake. Malformed, stalled and overrun frames are detected and reported.

Parameters:
DATA_WIDTH, 324, width of the reassembled word (81 nibbles × 4 bits).
UNIT_WIDTH, 4, nibble width; DATA_WIDTH must be a multiple of UNIT_WIDTH.
CHUNK_WIDTH, 8, UART byte width.
TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes inside a frame; 0 disables the timeout.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
uart_rx_data  input  CHUNK_WIDTH  received byte; qualified by uart_rx_valid
uart_rx_valid  input  1  one-cycle strobe, one per received byte
data_out  output  DATA_WIDTH  reassembled word; first byte lands in the MSBs
data_valid  output  1  data_out holds a complete frame
data_ready  input  1  consumer accepts data_out this cycle
busy  output  1  a frame is partially received (state RECEIVE)
frame_error  output  1  one-cycle pulse: frame dropped because of timeout or nonzero padding
overrun  output  1  one-cycle pulse: byte dropped while a completed frame was unaccepted

Behaviour:
- Derived constants: NUM_CHUNKS = ceil(DATA_WIDTH/CHUNK_WIDTH) = 41; PAD_BITS = NUM_CHUNKS*CHUNK_WIDTH - DATA_WIDTH = 4.
- Internal shift buffer sbuf is NUM_CHUNKS*CHUNK_WIDTH bits. Each accepted byte does sbuf <= {sbuf[...-CHUNK_WIDTH-1:0], uart_rx_data}.
- Byte counter cnt counts 0..NUM_CHUNKS-1. Idle counter tmo is sized to hold TIMEOUT_CYCLES.
- Reset: state=IDLE; cnt, tmo, sbuf = 0; data_out = 0; data_valid, busy, frame_error and overrun all 0.
- IDLE:
  - On uart_rx_valid: shift the byte in, cnt=1, tmo=0, go to RECEIVE.
- RECEIVE:
  - On uart_rx_valid: shift, cnt++, tmo=0.
  - If the byte is the NUM_CHUNKS-th:
    - If its low PAD_BITS bits are nonzero: pulse frame_error, cnt=0, go to IDLE. data_out and data_valid are unchanged.
    - Otherwise: data_out <= (full shifted buffer) >> PAD_BITS, data_valid=1, cnt=0, go to HOLD.
  - Latency: data_valid rises on the clock edge after the last byte's strobe.
  - With no byte this cycle: tmo++. When TIMEOUT_CYCLES != 0 and tmo reaches TIMEOUT_CYCLES-1, pulse frame_error, cnt=0, go to IDLE (partial frame discarded).
- HOLD:
  - data_valid stays 1 and data_out stays stable until data_valid && data_ready.
  - On that handshake: data_valid=0 next cycle, go to IDLE.
  - Byte arriving in HOLD without data_ready: byte dropped, overrun pulses, state unchanged.
  - Byte arriving in the same cycle as data_ready: handshake completes AND the byte is taken as byte 1 of the next frame (state RECEIVE, cnt=1, busy=1, no overrun).
- data_out is never cleared after a handshake; it keeps the last good frame until the next good frame completes.
- busy = (state == RECEIVE), registered.
- A single-nibble-aligned case with PAD_BITS=0 must also work: no padding check is done and data_out = sbuf.
- rst asserted mid-frame or in HOLD: all state returns to reset values on the next edge and the partial or pending frame is lost.

Decomposition:
- Shared package (sudoku_pkg): DATA_WIDTH/UNIT_WIDTH/CHUNK_WIDTH defaults, the NUM_CHUNKS and PAD_BITS derivation functions, and the state encoding (IDLE, RECEIVE, HOLD). The serializer uses the same package so both ends agree on frame geometry.
- One sub-module: idle_timeout_counter, parameterised by TIMEOUT_CYCLES. Inputs are clear and enable; output is an expiry pulse.

Test Plan:
- Golden frame: send 41 bytes 0x56, 0x78, 37×0x00, 0x01, 0x20 with 3 idle cycles between bytes → one cycle after the last strobe, data_valid=1 and data_out = {4'h5,4'h6,4'h7,4'h8,300'b0,4'h1,4'h2}; busy=0; frame_error and overrun never pulse.
- Bad padding: same frame but last byte 0x23 → frame_error pulses once, data_valid stays 0, state IDLE; the next golden frame is received correctly.
- Timeout: TIMEOUT_CYCLES=16, send 10 bytes then stop → frame_error pulses 16 cycles after the 10th byte, busy drops; a following full frame is reassembled correctly with no stale bytes.
- Back-pressure: data_ready=0 after the golden frame, then send 2 bytes → 2 overrun pulses, data_out unchanged; raise data_ready → data_valid falls on the next cycle.
- Simultaneous: a byte strobe in the same cycle as data_ready in HOLD → no overrun, busy=1, cnt=1, and the following 40 bytes complete the second frame.
- Reset mid-frame: assert rst after byte 20 → all outputs zero next cycle; a full frame after reset matches the golden value.
